barcode_encoder: RTL and testbench

- Transmit-side counterpart of the team's serial barcode reader.
- Accepts a data word of programmable length and emits the bar/white line sequence on B, one element per clock.
- The sequence is framed so the reader decodes every bit and then reports the end marker.
- Sits upstream of the reader in loopback test setups and drives the barcode line in the printer/emitter path.

---
 rtl/barcode_encoder.sv | 123 ++++++++++++
 tb/tb_barcode_encoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/barcode_encoder.sv
// rtl/barcode_encoder.sv - serial barcode line encoder (start bar, bit symbols, end bar, trailer)
module barcode_encoder #(
  parameter int MAX_BITS = 8,
  parameter int LW       = $clog2(MAX_BITS + 1),
  parameter int IDLE_GAP = 1
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  input  logic [MAX_BITS-1:0] Data,
  input  logic [LW-1:0]       Len,
  output logic                Ready,
  output logic                B,
  output logic                Done
);

  localparam int TW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [LW-1:0] MAX_LEN    = LW'(MAX_BITS);
  localparam logic [TW-1:0] TRAIL_LAST = TW'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_BAR,
    S_GAP,
    S_SYM_BAR,
    S_END_BAR,
    S_TRAIL
  } state_t;

  state_t              state;
  logic [MAX_BITS-1:0] shreg;      // payload, next bit to send in the MSB
  logic [LW-1:0]       rem;        // payload bits not yet terminated by a bar
  logic [1:0]          gap_cnt;    // extra white cycles left in the current gap
  logic [TW-1:0]       trail_cnt;  // trailer cycles left after the current one

  logic [LW-1:0]       len_clamped;
  logic [MAX_BITS-1:0] data_aligned;
  logic [MAX_BITS-1:0] shreg_next;

  // Clamp the length and left-align the payload so bit Len-1 lands in the MSB
  always_comb begin
    len_clamped  = (Len > MAX_LEN) ? MAX_LEN : Len;
    data_aligned = Data << (MAX_LEN - len_clamped);
    shreg_next   = shreg << 1;
  end

  // Frame sequencer; B, Ready and Done are registered alongside the state
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      rem       <= '0;
      gap_cnt   <= '0;
      trail_cnt <= '0;
      B         <= 1'b0;
      Ready     <= 1'b1;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            shreg <= data_aligned;
            rem   <= len_clamped;
            state <= S_START_BAR;
            B     <= 1'b1;
            Ready <= 1'b0;
          end
        end
        S_START_BAR: begin
          if (rem != '0) begin
            gap_cnt <= shreg[MAX_BITS-1] ? 2'd2 : 2'd0;
            state   <= S_GAP;
            B       <= 1'b0;
          end else begin
            state <= S_END_BAR;
            B     <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == 2'd0) begin
            state <= S_SYM_BAR;
            B     <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 2'd1;
          end
        end
        S_SYM_BAR: begin
          shreg <= shreg_next;
          if (rem != '0) rem <= rem - 1'b1;
          if (rem > LW'(1)) begin
            gap_cnt <= shreg_next[MAX_BITS-1] ? 2'd2 : 2'd0;
            state   <= S_GAP;
            B       <= 1'b0;
          end else begin
            state <= S_END_BAR;
            B     <= 1'b1;
          end
        end
        S_END_BAR: begin
          trail_cnt <= TRAIL_LAST;
          state     <= S_TRAIL;
          B         <= 1'b0;
        end
        S_TRAIL: begin
          if (trail_cnt == '0) begin
            state <= S_IDLE;
            Ready <= 1'b1;
            Done  <= 1'b1;
          end else begin
            trail_cnt <= trail_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          B     <= 1'b0;
          Ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_barcode_encoder.sv
// tb/tb_barcode_encoder.sv - scoreboard bench for barcode_encoder
module tb_barcode_encoder;
  localparam int MAX_BITS = 8;
  localparam int LW       = $clog2(MAX_BITS + 1);
  localparam int IDLE_GAP = 1;

  logic                Clk = 1'b0;
  logic                Rst = 1'b0;
  logic                Start = 1'b0;
  logic [MAX_BITS-1:0] Data = '0;
  logic [LW-1:0]       Len = '0;
  logic                Ready;
  logic                B;
  logic                Done;

  barcode_encoder #(.MAX_BITS(MAX_BITS), .LW(LW), .IDLE_GAP(IDLE_GAP)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Data(Data), .Len(Len),
    .Ready(Ready), .B(B), .Done(Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int data;
    int len;
  } pay_t;

  bit   exp_q[$];   // expected line elements, in order
  pay_t pay_q[$];   // expected payload per frame
  bit   cur[$];     // observed line elements of the frame in progress

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: build the line sequence straight from the symbol rules
  task automatic model_push(input int d, input int l);
    int   len_c;
    pay_t p;
    len_c = (l > MAX_BITS) ? MAX_BITS : l;
    exp_q.push_back(1'b1);
    for (int i = len_c - 1; i >= 0; i--) begin
      if ((d >> i) & 1) begin
        exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      end else begin
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      end
    end
    exp_q.push_back(1'b1);
    for (int i = 0; i < IDLE_GAP; i++) exp_q.push_back(1'b0);
    p.len  = len_c;
    p.data = d & ((1 << len_c) - 1);
    pay_q.push_back(p);
  endtask

  // Monitor: compare every busy-cycle element, decode the whole frame at Done
  int   m_i, m_z, m_nb, m_dec;
  bit   m_ok, m_fin, m_e;
  pay_t m_p;
  always @(negedge Clk) begin
    if (!Rst) begin
      cur.delete();
    end else if (!Ready) begin
      cur.push_back(B);
      if (exp_q.size() == 0) begin
        chk(1'b0, "b_unexpected", B, -1);
      end else begin
        m_e = exp_q.pop_front();
        chk(B == m_e, "b_stream", B, m_e);
      end
      chk(!Done, "done_while_busy", Done, 0);
    end else begin
      chk(B == 1'b0, "b_idle", B, 0);
      if (Done) begin
        if (pay_q.size() == 0) begin
          chk(1'b0, "done_spurious", Done, 0);
        end else begin
          m_p   = pay_q.pop_front();
          m_ok  = (cur.size() > 0) && cur[0];
          m_i   = 1; m_nb = 0; m_dec = 0; m_fin = 0;
          while (m_ok && !m_fin) begin
            m_z = 0;
            while (m_i < cur.size() && !cur[m_i]) begin m_z++; m_i++; end
            if (m_i >= cur.size()) m_ok = 0;
            else begin
              m_i++;
              if (m_z == 0) m_fin = 1;
              else if (m_z == 1) begin m_dec = m_dec << 1; m_nb++; end
              else if (m_z == 3) begin m_dec = (m_dec << 1) | 1; m_nb++; end
              else m_ok = 0;
            end
          end
          m_ok = m_ok && (cur.size() - m_i == IDLE_GAP);
          chk(m_ok && m_nb == m_p.len, "decode_len", m_nb, m_p.len);
          chk(m_dec == m_p.data, "decode_data", m_dec, m_p.data);
        end
        cur.delete();
      end
    end
  end

  // Issue one frame; optionally hold Start with junk while busy, or check back-to-back acceptance
  task automatic send(input int d, input int l, input bit hold, input bit b2b);
    int k;
    k = 0;
    @(negedge Clk);
    while (!Ready && k < 300) begin @(negedge Clk); k++; end
    if (!Ready) begin
      chk(1'b0, "ready_timeout", Ready, 1);
      return;
    end
    if (b2b) chk(Done, "b2b_done_cycle", Done, 1);
    Start = 1'b1;
    Data  = MAX_BITS'(d);
    Len   = LW'(l);
    model_push(d, l);
    @(posedge Clk); #1;
    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        Data = ~Data;
        Len  = LW'($urandom);
        @(posedge Clk); #1;
      end
    end
    Start = 1'b0;
    Data  = MAX_BITS'($urandom);
    Len   = LW'($urandom);
    if (b2b) begin
      @(negedge Clk);
      chk(B && !Ready, "b2b_start_bar", B, 1);
    end
  endtask

  initial begin
    int k;
    // Reset held with Start high
    Rst = 1'b0; Start = 1'b1; Data = 8'h5A; Len = 4'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk(B == 1'b0 && Ready && !Done, "reset_outputs", {B, Ready, Done}, 3'b010);
    end
    Start = 1'b0;
    #2 Rst = 1'b1;
    @(negedge Clk);
    chk(Ready && !B, "post_reset_idle", {Ready, B}, 2'b10);

    // Directed frames
    send(8'h05, 3, 0, 0);
    send(8'h00, 0, 0, 1);
    send(8'hFF, 9, 0, 1);
    send(8'h3C, 6, 1, 0);
    send(8'hA5, 8, 0, 1);

    // Reset during a gap of a full-length frame
    send(8'hA5, 8, 0, 0);
    repeat (3) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    chk(B == 1'b0 && Ready && !Done, "async_abort", {B, Ready, Done}, 3'b010);
    exp_q.delete();
    pay_q.delete();
    repeat (2) @(negedge Clk);
    #2 Rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk(!Done && Ready, "no_done_after_abort", {Done, Ready}, 2'b01);
    end
    send(8'hA5, 8, 0, 0);

    // Random frames, some with Start held during the frame
    for (int n = 0; n < 100; n++)
      send($urandom_range(0, 255), $urandom_range(0, 10), ($urandom_range(0, 3) == 0), 0);

    k = 0;
    while (pay_q.size() != 0 && k < 500) begin @(negedge Clk); k++; end
    chk(pay_q.size() == 0, "drain", pay_q.size(), 0);
    chk(exp_q.size() == 0, "drain_stream", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
